sc2bin_win: RTL and testbench
=============================

# sc2bin_win

Windowed stochastic-to-binary converter: counts the 1s of a unipolar bitstream over a programmable window of 2^k cycles and returns the count as a WIDTH-bit binary value. The value uses the same scale as the random-number comparators that produce the streams. It sits at the consuming end of the stochastic compute units: gdiv quotient streams, SNG outputs and multiplier outputs feed it. A valid/ready handshake delivers each result to the binary side.

## Interface
Parameters:
- WIDTH, 5, result width; max window 2^WIDTH cycles
- KW, $clog2(WIDTH+1), width of win_log2

Ports:
- clk  input  1  clock
- rst_n  input  1  reset; asynchronous, active-low
- start  input  1  request a conversion; honoured only in IDLE
- win_log2  input  KW  window exponent k, sampled with start; legal 1..WIDTH
- in_bit  input  1  stochastic bitstream under conversion
- busy  output  1  high in RUN and DONE
- out_valid  output  1  result available (DONE state)
- out_ready  input  1  consumer accepts result
- out_val  output  WIDTH  converted value, scaled to 2^WIDTH full range
- out_sat  output  1  every sampled bit was 1; out_val saturated

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE -> RUN on start=1:
  - latch k = win_log2; k=0 or k>WIDTH is clamped to WIDTH.
  - clear the ones counter (WIDTH+1 bits).
  - load the cycle counter with 2^k.
- RUN, each cycle:
  - ones += in_bit.
  - cycle counter decrements.
  - after the 2^k-th sample, go to DONE and register the result.
- Result arithmetic:
  - out_val = ones << (WIDTH-k), truncated to WIDTH bits.
  - if ones == 2^k: out_val = 2^WIDTH-1 and out_sat=1; otherwise out_sat=0.
  - This matches the divider's counter ceiling of all-ones.
- DONE -> IDLE when out_valid & out_ready at a clock edge.
- out_val and out_sat hold stable while out_valid=1. After the handshake they keep their last value; they are don't-care while out_valid=0.
- start is ignored in RUN and DONE, including the handshake cycle. A new conversion needs start in IDLE.
- win_log2 and start changes during RUN have no effect.

## Timing
- Reset values (asynchronous, immediate):
  - state = IDLE; busy = 0, out_valid = 0, out_val = 0, out_sat = 0.
  - ones and cycle counters are cleared.
- start is sampled at edge E0, entering RUN. in_bit is sampled at edges E1..E(2^k).
- out_valid rises after edge E(2^k). Latency from start to out_valid is 2^k+1 edges.
- busy rises after E0 and falls after the handshake edge.
- out_ready held high in DONE: out_valid lasts exactly one cycle.
- out_ready held low: out_valid, out_val and out_sat are held indefinitely.
- out_ready while not in DONE is ignored.
- rst_n asserted mid-RUN or mid-DONE: the conversion is aborted and no result is delivered. The first start after release begins a fresh window.
- Minimum spacing between conversions: 2^k+2 cycles (start, window, handshake).

## Structure
- Package sc2bin_pkg:
  - state_t enum {IDLE, RUN, DONE}.
  - default WIDTH constant, shared with the gdiv/SNG blocks.
- Sub-module sc2bin_acc: ones counter with clear and enable, WIDTH+1 bits, plus a saturation compare.
- The FSM, cycle counter, scaling shift and handshake live in the top module.

## Test plan
- Reset: hold rst_n low and wiggle start/in_bit -> all outputs 0, busy 0.
- k=5, in_bit 1 on exactly 12 of 32 cycles, out_ready=1 -> out_valid after 33 edges, out_val=12, out_sat=0, one-cycle pulse.
- k=3, pattern 10110010 (4 ones), WIDTH=5 -> out_val=16; all-ones pattern -> out_val=31, out_sat=1; all-zeros -> out_val=0.
- Backpressure: out_ready low for 10 cycles after done -> out_valid/out_val stable 10 cycles; start pulses in RUN/DONE ignored; handshake -> IDLE next cycle.
- Reset mid-RUN at cycle 7 of a k=5 window -> no out_valid. Next start with 32 ones -> out_val=31, with no carry-over.
- Chain from gdiv5b with dividend p=0.25 and divisor p=0.5, k=5, 20 runs -> mean out_val within ±3 of 16.

Source files
------------

// File: rtl/sc2bin_pkg.sv
// Shared types and defaults for the stochastic-to-binary converter.
// SC_WIDTH matches the comparator width used by the gdiv/SNG blocks.
package sc2bin_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int SC_WIDTH = 5;

endpackage

// File: rtl/sc2bin_acc.sv
// Ones counter for one conversion window, with look-ahead saturation flag.
// ones_nxt already includes the current sample so the top can register the final result on the last edge.
module sc2bin_acc
  import sc2bin_pkg::*;
#(
  parameter int WIDTH = SC_WIDTH,
  parameter int KW    = $clog2(WIDTH + 1)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clr,
  input  logic           en,
  input  logic           in_bit,
  input  logic [KW-1:0]  k,
  output logic [WIDTH:0] ones_nxt,
  output logic           sat_nxt
);

  localparam logic [WIDTH:0] ONE = {{WIDTH{1'b0}}, 1'b1};

  logic [WIDTH:0] ones;
  logic [WIDTH:0] full;

  assign ones_nxt = ones + {{WIDTH{1'b0}}, en & in_bit};
  assign full     = ONE << k;
  assign sat_nxt  = (ones_nxt == full);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ones <= '0;
    end else if (clr) begin
      ones <= '0;
    end else if (en) begin
      ones <= ones_nxt;
    end
  end

endmodule

// File: rtl/sc2bin_win.sv
// Windowed stochastic-to-binary converter: counts ones over 2^k cycles,
// rescales to the full WIDTH-bit range and hands the result off via valid/ready.
module sc2bin_win
  import sc2bin_pkg::*;
#(
  parameter int WIDTH = SC_WIDTH,
  parameter int KW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [KW-1:0]    win_log2,
  input  logic             in_bit,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_val,
  output logic             out_sat
);

  localparam logic [WIDTH:0]  ONE   = {{WIDTH{1'b0}}, 1'b1};
  localparam logic [KW-1:0]   K_MAX = KW'(WIDTH);

  state_t          state, state_nxt;
  logic [KW-1:0]   k_q, k_clamp;
  logic [WIDTH:0]  cnt;
  logic [WIDTH:0]  ones_nxt;
  logic            sat_nxt;
  logic            clr, en, last;

  // Returns {sat, value}: a full window of ones pins to the all-ones ceiling.
  function automatic logic [WIDTH:0] scale_sat(input logic [WIDTH:0] ones,
                                               input logic [KW-1:0]  k,
                                               input logic           sat);
    logic [WIDTH-1:0] sh;
    sh = WIDTH'(ones << (K_MAX - k));
    if (sat) return {1'b1, {WIDTH{1'b1}}};
    return {1'b0, sh};
  endfunction

  always_comb begin
    k_clamp = win_log2;
    if (win_log2 == '0 || win_log2 > K_MAX) k_clamp = K_MAX;
  end

  assign clr       = (state == IDLE) && start;
  assign en        = (state == RUN);
  assign last      = en && (cnt == ONE);
  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);

  sc2bin_acc #(.WIDTH(WIDTH), .KW(KW)) u_acc (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .en       (en),
    .in_bit   (in_bit),
    .k        (k_q),
    .ones_nxt (ones_nxt),
    .sat_nxt  (sat_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Window setup and countdown; k is frozen for the whole conversion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_q <= '0;
      cnt <= '0;
    end else if (clr) begin
      k_q <= k_clamp;
      cnt <= ONE << k_clamp;
    end else if (en) begin
      cnt <= cnt - ONE;
    end
  end

  // Result register, loaded on the edge that takes the final sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_val <= '0;
      out_sat <= 1'b0;
    end else if (last) begin
      {out_sat, out_val} <= scale_sat(ones_nxt, k_q, sat_nxt);
    end
  end

endmodule

// File: tb/tb_sc2bin_win.sv
// Scoreboard bench for sc2bin_win: expected {sat,val} queued at start, checked at handshake.
module tb_sc2bin_win;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [2:0] win_log2;
  logic       in_bit;
  logic       busy;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] out_val;
  logic       out_sat;

  int n_chk  = 0;
  int n_fail = 0;
  int mon_sum = 0;
  logic [5:0] sb_q[$];
  logic [5:0] mon_exp;

  always #5 clk = ~clk;

  sc2bin_win #(.WIDTH(5), .KW(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .win_log2  (win_log2),
    .in_bit    (in_bit),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_val   (out_val),
    .out_sat   (out_sat)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] model(input int ones, input int k);
    logic [4:0] v;
    if (ones == (1 << k)) return 6'h3F;
    v = 5'((ones << (5 - k)) & 31);
    return {1'b0, v};
  endfunction

  // Output monitor: one pop per accepted result.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_valid", 32'd1, 32'd0);
      end else begin
        mon_exp = sb_q.pop_front();
        chk("out_val", 32'(out_val), 32'(mon_exp[4:0]));
        chk("out_sat", 32'(out_sat), 32'(mon_exp[5]));
        mon_sum += int'(out_val);
      end
    end
  end

  // Entered and left at posedge+1. Bit i of pat is sampled at edge E(i+1).
  task automatic convert(input int kin, input logic [31:0] pat, input bit poke);
    int ke, n, ones;
    ke = (kin == 0 || kin > 5) ? 5 : kin;
    n = 1 << ke;
    ones = 0;
    for (int i = 0; i < n; i++) ones += int'(pat[i]);
    sb_q.push_back(model(ones, ke));
    start = 1'b1;
    win_log2 = 3'(kin);
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_rise", 32'(busy), 32'd1);
    for (int i = 0; i < n; i++) begin
      in_bit = pat[i];
      if (poke && i == 2) begin
        start = 1'b1;
        win_log2 = 3'd1;
      end else begin
        start = 1'b0;
      end
      if (i == n - 1) chk("valid_early", 32'(out_valid), 32'd0);
      @(posedge clk); #1;
    end
    start = 1'b0;
    in_bit = 1'b0;
    chk("valid_rise", 32'(out_valid), 32'd1);
    if (out_ready) begin
      @(posedge clk); #1;
      chk("valid_pulse", 32'(out_valid), 32'd0);
      chk("busy_fall", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] pat;
    rst_n = 1'b0;
    start = 1'b0;
    win_log2 = 3'd5;
    in_bit = 1'b0;
    out_ready = 1'b1;

    // Reset held: wiggle inputs, outputs must stay cleared.
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      start = c[0];
      in_bit = ~c[0];
    end
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_val", 32'(out_val), 32'd0);
    chk("rst_sat", 32'(out_sat), 32'd0);
    start = 1'b0;
    in_bit = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    convert(5, 32'h0F0F_0F00, 1'b0);           // 12 ones -> 12
    convert(3, 32'(8'b10110010), 1'b0);        // 4 ones -> 16
    convert(3, 32'h0000_00FF, 1'b0);           // full -> 31, sat
    convert(3, 32'h0000_0000, 1'b0);           // 0
    convert(1, 32'h0000_0002, 1'b0);           // 1 of 2 -> 16
    convert(1, 32'h0000_0003, 1'b0);           // sat
    convert(0, 32'h0000_00FF, 1'b0);           // k clamps to 5 -> 8
    convert(7, 32'h8000_0001, 1'b0);           // k clamps to 5 -> 2
    convert(4, 32'h0000_7FFF, 1'b0);           // 15 of 16 -> 30

    // Backpressure with start pokes in RUN and DONE.
    out_ready = 1'b0;
    convert(3, 32'(8'b11010110), 1'b1);        // 5 ones -> 20
    for (int c = 0; c < 10; c++) begin
      start = (c % 3 == 0);
      win_log2 = 3'd1;
      @(posedge clk); #1;
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_val", 32'(out_val), 32'd20);
    end
    out_ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("hs_busy", 32'(busy), 32'd0);
    chk("hs_valid", 32'(out_valid), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("no_restart", 32'(busy), 32'd0);

    // Reset during RUN after 7 ones of a k=5 window.
    start = 1'b1;
    win_log2 = 3'd5;
    @(posedge clk); #1;
    start = 1'b0;
    in_bit = 1'b1;
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_valid", 32'(out_valid), 32'd0);
    chk("abort_val", 32'(out_val), 32'd0);
    in_bit = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("abort_no_result", 32'(out_valid), 32'd0);
    convert(5, 32'hFFFF_FFFF, 1'b0);           // fresh window -> 31, sat

    // Quotient stream of p=0.25/0.5 = 0.5 feeding 20 k=5 windows.
    mon_sum = 0;
    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < 32; i++) pat[i] = ($urandom_range(0, 31) < 16);
      convert(5, pat, 1'b0);
    end
    chk("chain_mean_in_range", 32'((mon_sum >= 260) && (mon_sum <= 380)), 32'd1);

    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
